// File: rtl/wb_arbiter.sv
// wb_arbiter
// ----------
// Writeback arbiter and register scoreboard for a register file with a
// single write port. Two writeback requesters (ALU result, memory load) share
// the port under round-robin arbitration. A busy bit per register marks an
// outstanding write, so issue stalls on read-after-write and write-after-write
// hazards.
//
// Optional feature macro: WB_R0_DISCARD_EN
//   defined   : register 0 is hardwired zero. A writeback to it completes its
//               handshake and updates the round-robin state, but it never
//               raises RegWrite. Busy[0] is never set, and index 0 never
//               causes a stall.
//   undefined : register 0 is an ordinary, tracked register.
//
// Ports
//   Clk, Reset_n          clock (rising edge), asynchronous active-low reset
//   Issue_valid/rd/rs1/rs2/uses_rs2
//                         instruction offered for issue
//   Issue_stall           combinational; issue must hold this cycle
//   Alu_valid/rd/data     ALU writeback request; Alu_ready is its grant
//   Mem_valid/rd/data     load writeback request; Mem_ready is its grant
//   RegWrite/Write_register/Write_data
//                         registered write to the register file
//   Busy                  registered scoreboard, one bit per register
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Issue_valid,
    input  logic [ADDR_W-1:0]      Issue_rd,
    input  logic [ADDR_W-1:0]      Issue_rs1,
    input  logic [ADDR_W-1:0]      Issue_rs2,
    input  logic                   Issue_uses_rs2,
    output logic                   Issue_stall,
    input  logic                   Alu_valid,
    input  logic [ADDR_W-1:0]      Alu_rd,
    input  logic [DATA_W-1:0]      Alu_data,
    output logic                   Alu_ready,
    input  logic                   Mem_valid,
    input  logic [ADDR_W-1:0]      Mem_rd,
    input  logic [DATA_W-1:0]      Mem_data,
    output logic                   Mem_ready,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      Write_register,
    output logic [DATA_W-1:0]      Write_data,
    output logic [(2**ADDR_W)-1:0] Busy
);

    localparam int   NREGS     = 2**ADDR_W;
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    logic              last_grant;
    logic              wb_fire;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              commit_en;
    logic              issue_fire;
    logic              hazard_rs1;
    logic              hazard_rs2;
    logic              hazard_rd;
    logic [NREGS-1:0]  busy_next;

    // Round-robin grant. A lone request is always granted. Under contention,
    // the requester that did not win last time is granted. The grant uses only
    // the valids and last_grant, so it never depends on the request data.
    always_comb begin
        Alu_ready = Alu_valid && (!Mem_valid || (last_grant == GRANT_MEM));
        Mem_ready = Mem_valid && (!Alu_valid || (last_grant == GRANT_ALU));
        wb_fire   = Alu_ready || Mem_ready;
        wb_rd     = Alu_ready ? Alu_rd   : Mem_rd;
        wb_data   = Alu_ready ? Alu_data : Mem_data;
    end

    // Hazard check. It looks only at the registered Busy vector. A writeback
    // in the same cycle therefore releases the stall one cycle later.
    always_comb begin
`ifdef WB_R0_DISCARD_EN
        hazard_rs1 = Busy[Issue_rs1] && (Issue_rs1 != '0);
        hazard_rs2 = Busy[Issue_rs2] && (Issue_rs2 != '0);
        hazard_rd  = Busy[Issue_rd]  && (Issue_rd  != '0);
        commit_en  = wb_fire && (wb_rd != '0);
`else
        hazard_rs1 = Busy[Issue_rs1];
        hazard_rs2 = Busy[Issue_rs2];
        hazard_rd  = Busy[Issue_rd];
        commit_en  = wb_fire;
`endif
        Issue_stall = Issue_valid &&
                      (hazard_rs1 || (Issue_uses_rs2 && hazard_rs2) || hazard_rd);
        issue_fire  = Issue_valid && !Issue_stall;
    end

    // Scoreboard update. The set is applied after the clear, so that an issue
    // and a writeback to the same register on one edge leave it busy.
    always_comb begin
        busy_next = Busy;
        if (wb_fire) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[Issue_rd] = 1'b1;
        end
`ifdef WB_R0_DISCARD_EN
        busy_next[0] = 1'b0;
`endif
    end

    // Commit stage and state registers. Write_register/Write_data keep their
    // value when nothing is accepted. Only RegWrite drops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
            Busy           <= '0;
            last_grant     <= GRANT_MEM;
        end else begin
            RegWrite <= commit_en;
            Busy     <= busy_next;
            if (wb_fire) begin
                Write_register <= wb_rd;
                Write_data     <= wb_data;
                last_grant     <= Mem_ready ? GRANT_MEM : GRANT_ALU;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// -------------
// Bench for wb_arbiter (DATA_W=32, ADDR_W=5). A reference model of the grant,
// commit and scoreboard behaviour runs one cycle at a time. For each cycle it
// pushes the expected commit onto a queue. After the clock edge that entry is
// popped and compared with the registered outputs.
module tb_wb_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic        Issue_valid;
    logic [4:0]  Issue_rd;
    logic [4:0]  Issue_rs1;
    logic [4:0]  Issue_rs2;
    logic        Issue_uses_rs2;
    logic        Issue_stall;
    logic        Alu_valid;
    logic [4:0]  Alu_rd;
    logic [31:0] Alu_data;
    logic        Alu_ready;
    logic        Mem_valid;
    logic [4:0]  Mem_rd;
    logic [31:0] Mem_data;
    logic        Mem_ready;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [31:0] Busy;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } commit_t;

    commit_t     expQ[$];
    int          compareCount;
    int          mismatchCount;
    logic [31:0] mBusy;
    logic        mLastMem;
    logic [4:0]  mWr;
    logic [31:0] mWd;
    logic        obsAluReady;
    logic        obsMemReady;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Issue_valid(Issue_valid), .Issue_rd(Issue_rd), .Issue_rs1(Issue_rs1),
        .Issue_rs2(Issue_rs2), .Issue_uses_rs2(Issue_uses_rs2), .Issue_stall(Issue_stall),
        .Alu_valid(Alu_valid), .Alu_rd(Alu_rd), .Alu_data(Alu_data), .Alu_ready(Alu_ready),
        .Mem_valid(Mem_valid), .Mem_rd(Mem_rd), .Mem_data(Mem_data), .Mem_ready(Mem_ready),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
        .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model view of a busy bit. With the R0 option, register 0 is never busy.
    function automatic logic modelBusy(input logic [4:0] idx);
`ifdef WB_R0_DISCARD_EN
        if (idx == 5'd0) return 1'b0;
`endif
        return mBusy[idx];
    endfunction

    task automatic modelReset();
        mBusy    = '0;
        mLastMem = 1'b1;
        mWr      = '0;
        mWd      = '0;
        expQ.delete();
    endtask

    task automatic clearInputs();
        Issue_valid = 0; Issue_rd = 0; Issue_rs1 = 0; Issue_rs2 = 0; Issue_uses_rs2 = 0;
        Alu_valid = 0; Alu_rd = 0; Alu_data = 0;
        Mem_valid = 0; Mem_rd = 0; Mem_data = 0;
    endtask

    // Runs one clock cycle. Inputs are driven on the falling edge and the
    // combinational outputs are checked against the model. The expected commit
    // is queued, and after the rising edge the registered outputs are checked.
    task automatic applyStimulus(
        input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
        input logic [4:0] irs2, input logic iu2,
        input logic av, input logic [4:0] ard, input logic [31:0] adata,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
        output logic gotAlu, output logic gotMem);
        logic        expStall, expAlu, expMem;
        logic [31:0] nb;
        commit_t     c, o;
        @(negedge Clk);
        Issue_valid = iv; Issue_rd = ird; Issue_rs1 = irs1; Issue_rs2 = irs2;
        Issue_uses_rs2 = iu2;
        Alu_valid = av; Alu_rd = ard; Alu_data = adata;
        Mem_valid = mv; Mem_rd = mrd; Mem_data = mdata;
        #1;
        expStall = iv && (modelBusy(irs1) || (iu2 && modelBusy(irs2)) || modelBusy(ird));
        expAlu   = av && (!mv || mLastMem);
        expMem   = mv && (!av || !mLastMem);
        obsAluReady = Alu_ready;
        obsMemReady = Mem_ready;
        checkOutput("issue_stall", 64'(Issue_stall), 64'(expStall));
        checkOutput("alu_ready", 64'(Alu_ready), 64'(expAlu));
        checkOutput("mem_ready", 64'(Mem_ready), 64'(expMem));
        nb = mBusy;
        c.we = 1'b0; c.rd = mWr; c.data = mWd;
        if (expAlu || expMem) begin
            c.rd   = expAlu ? ard : mrd;
            c.data = expAlu ? adata : mdata;
            c.we   = 1'b1;
`ifdef WB_R0_DISCARD_EN
            if (c.rd == 5'd0) c.we = 1'b0;
`endif
            nb[c.rd] = 1'b0;
            mLastMem = expMem;
            mWr = c.rd;
            mWd = c.data;
        end
        if (iv && !expStall) nb[ird] = 1'b1;
`ifdef WB_R0_DISCARD_EN
        nb[0] = 1'b0;
`endif
        mBusy = nb;
        expQ.push_back(c);
        gotAlu = expAlu;
        gotMem = expMem;
        @(posedge Clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            o = expQ.pop_front();
            checkOutput("reg_write", 64'(RegWrite), 64'(o.we));
            checkOutput("write_register", 64'(Write_register), 64'(o.rd));
            checkOutput("write_data", 64'(Write_data), 64'(o.data));
        end
        checkOutput("busy", 64'(Busy), 64'(mBusy));
    endtask

    task automatic idleCycle();
        logic ga, gm;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    endtask

    initial begin
        logic       ga, gm;
        logic [3:0] grantSeq;
        int         ai, mi;
        compareCount  = 0;
        mismatchCount = 0;
        clearInputs();
        modelReset();

        // Power-on reset: check every registered output and the idle grants.
        Reset_n = 1'b0;
        #12;
        checkOutput("rst_busy", 64'(Busy), 64'd0);
        checkOutput("rst_reg_write", 64'(RegWrite), 64'd0);
        checkOutput("rst_write_register", 64'(Write_register), 64'd0);
        checkOutput("rst_write_data", 64'(Write_data), 64'd0);
        checkOutput("rst_alu_ready", 64'(Alu_ready), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Continuous contention right after reset: expect ALU, MEM, ALU, MEM.
        // Each requester holds its request until it is accepted.
        ai = 0; mi = 0; grantSeq = '0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0,
                          1, 5'(10 + ai), 32'hA000_0000 + 32'(ai),
                          1, 5'(16 + mi), 32'hB000_0000 + 32'(mi), ga, gm);
            grantSeq[3-i] = obsAluReady;
            if (ga) ai++;
            if (gm) mi++;
        end
        checkOutput("grant_sequence", 64'(grantSeq), 64'(4'b1010));
        idleCycle();

        // Issue without hazards, then a RAW stall on r3 that a same-cycle ALU
        // writeback does not release. The held issue goes through on the next cycle.
        applyStimulus(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, ga, gm);
        applyStimulus(1, 4, 3, 0, 0, 1, 3, 32'h0000_000F, 0, 0, 0, ga, gm);
        applyStimulus(1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h1234_5678, ga, gm);

        // Write to a register that is not busy, then set and clear r20 together.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 25, 32'd15, ga, gm);
        applyStimulus(1, 20, 0, 0, 0, 1, 20, 32'hDEAD_BEEF, 0, 0, 0, ga, gm);
        applyStimulus(1, 3, 1, 2, 1, 1, 7, 32'h0000_0777, 0, 0, 0, ga, gm);
        checkOutput("busy_before_reset", 64'(Busy), 64'h0010_0008);

        // Mid-cycle asynchronous reset: state clears with no clock edge.
        #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("async_busy", 64'(Busy), 64'd0);
        checkOutput("async_reg_write", 64'(RegWrite), 64'd0);
        checkOutput("async_write_register", 64'(Write_register), 64'd0);
        modelReset();
        clearInputs();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Register 0 handling: a write to r0 and an issue to r0, then a read of r0.
        applyStimulus(1, 0, 1, 2, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, ga, gm);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, ga, gm);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
